mem16kb_arbiter: RTL

Four-port round-robin arbiter that shares the single-port 16 KB byte memory (four 4 KB banks, 14-bit address, 8-bit data, synchronous write, registered read) between four requesters. It grants at most one access per cycle, drives the memory port, and routes registered read data back with a per-requester valid strobe. It also supports a lock mode so one requester can own back-to-back bursts. It sits between the requesting masters and the 16 KB memory instance.

---
 rtl/mem16kb_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem16kb_arbiter.sv
// rtl/mem16kb_arbiter.sv - four-port round-robin arbiter with lock mode for the 16 KB byte memory
//
// Shares one single-port memory (synchronous write, registered read) between
// four requesters. At most one access is granted per cycle. The granted
// requester's address/data/we drive the memory port directly, so grant
// latency is zero. Read data returns one cycle later, tagged with a
// per-requester rvalid strobe.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req[3:0]        per-requester request, held until granted
//   req_we[3:0]     per-requester write enable (1 = write)
//   req_lock[3:0]   per-requester lock; keeps the grant across cycles
//   req_addr        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata       packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt[3:0]        one-hot grant, combinational in the accepted cycle
//   rvalid[3:0]     one-cycle read-return strobe
//   rdata           shared read data, qualified by rvalid
//   mem_addr, mem_data_in, mem_we   memory command port
//   mem_data_out    memory registered read data
module mem16kb_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          req_we,
  input  logic [3:0]          req_lock,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          gnt,
  output logic [3:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data_in,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_data_out
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic                rd_pend_q, rd_pend_d;
  logic [1:0]          rd_id_q, rd_id_d;

  // Last driven command, so the memory port holds its value on idle cycles.
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [ADDR_W-1:0]   addr_arr  [4];
  logic [DATA_W-1:0]   wdata_arr [4];

  logic                win_valid;
  logic [1:0]          win;
  logic [1:0]          idx;
  logic                take;
  logic                grant;
  logic [1:0]          sel;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Rotating priority search: scanning offsets from 3 down to 0 lets the
  // smallest offset from ptr (highest priority) overwrite the result last.
  always_comb begin
    win_valid = 1'b0;
    win       = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        win_valid = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    take    = 1'b0;
    sel     = win;
    case (state_q)
      ARB: begin
        if (win_valid) begin
          take  = 1'b1;
          sel   = win;
          ptr_d = win + 2'd1;
          if (req_lock[win]) begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        // Only the owner may be served; everyone else waits.
        ptr_d = owner_q + 2'd1;
        if (req[owner_q]) begin
          take = 1'b1;
          sel  = owner_q;
          if (!req_lock[owner_q]) begin
            state_d = ARB;
          end
        end else begin
          state_d = ARB;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Grants and writes are suppressed while reset is held, independent of req.
  assign grant = take & ~rst;

  always_comb begin
    gnt = 4'b0000;
    if (grant) begin
      gnt[sel] = 1'b1;
    end
  end

  assign mem_we      = grant & req_we[sel];
  assign mem_addr    = grant ? addr_arr[sel]  : addr_q;
  assign mem_data_in = grant ? wdata_arr[sel] : wdata_q;

  always_comb begin
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    if (grant && !req_we[sel]) begin
      rd_pend_d = 1'b1;
      rd_id_d   = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      addr_q    <= mem_addr;
      wdata_q   <= mem_data_in;
    end
  end

  // The memory registers its read output, so the returning data lines up
  // with the cycle after the grant.
  assign rvalid = rd_pend_q ? (4'b0001 << rd_id_q) : 4'b0000;
  assign rdata  = rd_pend_q ? mem_data_out : '0;

endmodule
